instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 25 ++
 rtl/instr_sequencer_if.sv | 45 ++++
 rtl/instr_sequencer_step_counter.sv | 29 ++
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 10-bit processor instruction issue unit.
// Contents: FSM state enum, TIME step constants, instruction width and a
// saturating 8-bit increment used for the retired-instruction counter.
package proc_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its environment
// (program memory + controller).
//   RUN, MEM_DATA, DONE, STEP : into the sequencer
//   MEM_ADDR, MEM_RD          : program memory address / read strobe
//   INSTR, TIME               : current instruction and step to the controller
//   BUSY, HALTED, TIMEOUT     : status
//   ICOUNT                    : saturating retired-instruction count
// Optional: SINGLE_STEP_EN adds the STEP input.
// Modports: slave = sequencer side, master = environment side.
interface instr_sequencer_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 6
);
    logic              RUN;
    logic [DATA_W-1:0] MEM_DATA;
    logic              DONE;
`ifdef SINGLE_STEP_EN
    logic              STEP;
`endif
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RD;
    logic [DATA_W-1:0] INSTR;
    logic [1:0]        TIME;
    logic              BUSY;
    logic              HALTED;
    logic              TIMEOUT;
    logic [7:0]        ICOUNT;

    modport slave (
        input  RUN, MEM_DATA, DONE,
`ifdef SINGLE_STEP_EN
        input  STEP,
`endif
        output MEM_ADDR, MEM_RD, INSTR, TIME, BUSY, HALTED, TIMEOUT, ICOUNT
    );

    modport master (
        output RUN, MEM_DATA, DONE,
`ifdef SINGLE_STEP_EN
        output STEP,
`endif
        input  MEM_ADDR, MEM_RD, INSTR, TIME, BUSY, HALTED, TIMEOUT, ICOUNT
    );

endinterface

// File: rtl/instr_sequencer_step_counter.sv
// 2-bit TIME step counter for the instruction sequencer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to T0 (takes priority over en)
//   en       : advance count by one
//   count    : current step value
//   tc       : terminal count (count == T3), used for the timeout retire
module step_counter
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] count,
    output logic       tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= T0;
        end else if (en) begin
            count <= count + 2'd1;
        end
    end

    assign tc = (count == T3);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issue unit: fetches words from a synchronous program memory,
// holds each on INSTR for its execute window, counts TIME steps and retires
// on DONE (TIME >= 1) or on a TIME == 3 timeout.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : instr_sequencer_if.slave (memory, controller, status signals)
// Optional feature macro: SINGLE_STEP_EN (STEP input, one instruction per
// rising STEP edge while idle with RUN high).
//
// state   | meaning
// S_IDLE  | waiting for RUN (or a STEP edge in single-step builds)
// S_FETCH | MEM_RD asserted for one cycle at PC
// S_LOAD  | memory data captured into INSTR, TIME cleared
// S_EXEC  | TIME counts 0..3 until DONE or timeout retires the instruction
// S_HALT  | last word retired without wrap; only RST leaves
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int                DATA_W     = proc_pkg::DATA_W,
    parameter int                ADDR_W     = 6,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}},
    parameter bit                WRAP       = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    instr_sequencer_if.slave   bus
);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [DATA_W-1:0]  instr;
    logic [7:0]         icount;
    logic [1:0]         step;
    logic               tc;
    logic               cnt_clr, cnt_en;
    logic               retire, timeout, mem_rd;
    logic               start, cont;

`ifdef SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.STEP;
        end
    end

    // Edges seen outside S_IDLE are simply not consumed.
    assign start = bus.RUN & bus.STEP & ~step_q;
    assign cont  = 1'b0;
`else
    assign start = bus.RUN;
    assign cont  = bus.RUN;
`endif

    step_counter u_step (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (step),
        .tc    (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            pc     <= START_ADDR;
            instr  <= '0;
            icount <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_LOAD) begin
                instr <= bus.MEM_DATA;
            end
            if (retire) begin
                icount <= sat_inc8(icount);
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        retire   = 1'b0;
        timeout  = 1'b0;
        mem_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd   = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                cnt_clr  = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                // DONE at T0 may be left over from the previous instruction.
                if ((bus.DONE && (step != T0)) || tc) begin
                    retire  = 1'b1;
                    timeout = tc & ~bus.DONE;
                    cnt_clr = 1'b1;
                    if ((pc == LAST_ADDR) && !WRAP) begin
                        state_nx = S_HALT;
                    end else begin
                        pc_nx    = (pc == LAST_ADDR) ? START_ADDR : pc + ADDR_W'(1);
                        state_nx = cont ? S_FETCH : S_IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.MEM_ADDR = pc;
    assign bus.MEM_RD   = mem_rd;
    assign bus.INSTR    = instr;
    assign bus.TIME     = step;
    assign bus.BUSY     = (state == S_FETCH) || (state == S_LOAD) || (state == S_EXEC);
    assign bus.HALTED   = (state == S_HALT);
    assign bus.TIMEOUT  = timeout;
    assign bus.ICOUNT   = icount;

endmodule
